// File: rtl/common_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : common_types_pkg
//  Description : Shared types for the AXI memory controller: 32-bit word,
//                AXI response codes, controller FSM state encoding and a few
//                constants/helpers used by the datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package common_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_RESP  = 3'd5
  } ctrl_state_t;

  localparam logic [2:0] c_ARSIZE_WORD  = 3'b010;
  localparam word_t      c_TIMEOUT_LOAD = 32'hDEAD_BEEF;

  // Anything other than OKAY (including EXOKAY, which we never request)
  // is reported to the CPU as an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != 2'(RESP_OKAY);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_wstrb_gen.sv
`default_nettype none
// ============================================================================
//  Module      : axi_wstrb_gen
//  Description : Write-lane steering. Replicates the right-aligned store data
//                across byte lanes, builds the byte strobe from the size and
//                low address bits, and flags misaligned half/word accesses.
//  Ports       : size_i      - 00 none, 01 byte, 10 half, 11 word
//                addr_lo_i   - byte address bits [1:0]
//                store_i     - right-aligned write data
//                wstrb_o     - byte lane strobes
//                wdata_o     - lane-replicated write data
//                misaligned_o- half on odd address or word not on 4-byte bound
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_wstrb_gen
  import common_types_pkg::*;
(
  input  logic [1:0] size_i,
  input  logic [1:0] addr_lo_i,
  input  word_t      store_i,
  output logic [3:0] wstrb_o,
  output word_t      wdata_o,
  output logic       misaligned_o
);

  always_comb begin
    wstrb_o      = 4'b0000;
    wdata_o      = store_i;
    misaligned_o = 1'b0;
    case (size_i)
      2'b01: begin
        wstrb_o = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_i[7:0]}};
      end
      2'b10: begin
        wstrb_o      = 4'b0011 << addr_lo_i;
        wdata_o      = {2{store_i[15:0]}};
        misaligned_o = addr_lo_i[0];
      end
      2'b11: begin
        wstrb_o      = 4'b1111;
        misaligned_o = |addr_lo_i;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/axi_mem_controller.sv
`default_nettype none
// ============================================================================
//  Module      : axi_mem_controller
//  Description : Single-outstanding CPU-to-AXI bridge. A CPU read/write
//                request sampled in IDLE becomes one AXI transfer; the result
//                is presented on ready/load/error until the CPU acks with done.
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                read, write, addr,    - CPU request (write = size code),
//                store, done             data and acknowledge
//                ready, load, error    - CPU response
//                aw*/w*/b*/ar*/r*      - AXI4-Lite style master channels
//  Options     : `define AXI_CTRL_TIMEOUT_EN adds a per-state handshake
//                timeout of TIMEOUT_CYCLES; without it the FSM waits forever.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_mem_controller
  import common_types_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic [1:0]        write,
  input  logic [ADDR_W-1:0] addr,
  input  word_t             store,
  input  logic              done,
  output logic              ready,
  output word_t             load,
  output logic              error,
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awsize,
  output logic              awvalid,
  input  logic              awready,
  output word_t             wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arsize,
  output logic              arvalid,
  input  logic              arready,
  input  word_t             rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready
);

  ctrl_state_t       state_q, state_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic              bready_q, bready_d, arvalid_q, arvalid_d;
  logic              rready_q, rready_d, ready_q, ready_d;
  logic              error_q, error_d;
  word_t             load_q, load_d;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        awsize_q;
  word_t             wdata_q;
  logic [3:0]        wstrb_q;

  logic [3:0]        w_wstrb;
  word_t             w_wdata;
  logic              w_wr_misaligned;
  logic              w_aw_done, w_w_done;

  axi_wstrb_gen u_wstrb_gen (
    .size_i       (write),
    .addr_lo_i    (addr[1:0]),
    .store_i      (store),
    .wstrb_o      (w_wstrb),
    .wdata_o      (w_wdata),
    .misaligned_o (w_wr_misaligned)
  );

  // A channel counts as accepted once its valid has dropped or it handshakes now.
  assign w_aw_done = !awvalid_q || awready;
  assign w_w_done  = !wvalid_q  || wready;

`ifdef AXI_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_cnt_hit;
  logic             timeout_fire;

  assign w_cnt_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  // Restart on every state change so each bus phase gets its own budget.
  assign cnt_d     = (state_d != state_q) ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
`ifdef AXI_CTRL_TIMEOUT_EN
    timeout_fire = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (write != 2'b00)  state_d = w_wr_misaligned ? ST_RESP : ST_WRITE;
        else if (read)       state_d = (|addr[1:0]) ? ST_RESP : ST_RADDR;
      end
      ST_WRITE: if (w_aw_done && w_w_done) state_d = ST_WRESP;
      ST_WRESP: if (bvalid)                state_d = ST_RESP;
      ST_RADDR: if (arready)               state_d = ST_RDATA;
      ST_RDATA: if (rvalid)                state_d = ST_RESP;
      ST_RESP:  if (done)                  state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
`ifdef AXI_CTRL_TIMEOUT_EN
    // Only a phase that is still stuck times out; a handshake this cycle wins.
    if (w_cnt_hit && state_d == state_q &&
        (state_q == ST_WRITE || state_q == ST_WRESP ||
         state_q == ST_RADDR || state_q == ST_RDATA)) begin
      state_d      = ST_RESP;
      timeout_fire = 1'b1;
    end
`endif
  end

  // Output logic: next values of the registered handshake/response outputs
  always_comb begin
    awvalid_d = 1'b0;
    wvalid_d  = 1'b0;
    if (state_d == ST_WRITE) begin
      awvalid_d = (state_q == ST_IDLE) ? 1'b1 : (awvalid_q && !awready);
      wvalid_d  = (state_q == ST_IDLE) ? 1'b1 : (wvalid_q  && !wready);
    end
    bready_d  = (state_d == ST_WRESP);
    arvalid_d = (state_d == ST_RADDR);
    rready_d  = (state_d == ST_RDATA);
    ready_d   = (state_d == ST_RESP);
    error_d   = error_q;
    load_d    = load_q;
    case (state_q)
      ST_IDLE: begin
        if (state_d == ST_RESP) begin
          // Misaligned request: complete locally without touching the bus.
          error_d = 1'b1;
          load_d  = '0;
        end else if (state_d != ST_IDLE) begin
          error_d = 1'b0;
        end
      end
      ST_WRESP: if (bvalid) error_d = resp_is_err(bresp);
      ST_RDATA: begin
        if (rvalid) begin
          load_d  = rdata;
          error_d = resp_is_err(rresp);
        end
      end
      default: ;
    endcase
`ifdef AXI_CTRL_TIMEOUT_EN
    if (timeout_fire) begin
      error_d = 1'b1;
      load_d  = c_TIMEOUT_LOAD;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      load_q    <= '0;
    end else begin
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
      load_q    <= load_d;
    end
  end

  // Request fields are captured in IDLE so later CPU changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      awsize_q <= 3'b000;
      wdata_q  <= '0;
      wstrb_q  <= 4'b0000;
    end else if (state_q == ST_IDLE) begin
      addr_q   <= addr;
      awsize_q <= {1'b0, write - 2'd1};
      wdata_q  <= w_wdata;
      wstrb_q  <= w_wstrb;
    end
  end

  assign ready   = ready_q;
  assign load    = load_q;
  assign error   = error_q;
  assign awaddr  = addr_q;
  assign awsize  = awsize_q;
  assign awvalid = awvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;
  assign araddr  = addr_q;
  assign arsize  = c_ARSIZE_WORD;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_mem_controller
//  Description : Directed bench for axi_mem_controller. Stimulus pushes the
//                expected CPU response and expected AW/W/AR beats into queues;
//                independent monitors pop and compare as the DUT presents them.
//                Timeout vector is included when AXI_CTRL_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_mem_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        read;
  logic [1:0]  write;
  logic [31:0] addr, store;
  logic        done;
  logic        ready, error;
  logic [31:0] load;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0]  awsize, arsize;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic [3:0]  wstrb;

  // Slave model configuration
  logic        aw_en = 1'b1;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [1:0]  rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;
  int          r_wait = 0;
  int          rcnt = 0;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed { logic [31:0] load; logic err; } resp_t;
  typedef struct packed { logic [31:0] a; logic [2:0] size; } aw_t;
  typedef struct packed { logic [31:0] d; logic [3:0] strb; } w_t;
  resp_t       exp_q[$];
  aw_t         aw_q[$];
  w_t          w_q[$];
  logic [31:0] ar_q[$];

  always #5 clk = ~clk;

  axi_mem_controller dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr),
    .store(store), .done(done), .ready(ready), .load(load), .error(error),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  // Zero-wait slave except for programmable read-data latency.
  assign awready = aw_en;
  assign wready  = 1'b1;
  assign bvalid  = bready;
  assign bresp   = bresp_cfg;
  assign arready = 1'b1;
  assign rdata   = rdata_cfg;
  assign rresp   = rresp_cfg;
  assign rvalid  = rready && (rcnt >= r_wait);

  always @(posedge clk) begin
    if (!rready || rvalid) rcnt <= 0;
    else                   rcnt <= rcnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // CPU response monitor: first ready cycle pops the scoreboard, later ready
  // cycles must hold load/error stable.
  initial begin : resp_mon
    logic        seen;
    logic [31:0] h_load;
    logic        h_err;
    resp_t       e;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !ready) begin
        seen = 1'b0;
      end else if (!seen) begin
        seen = 1'b1; h_load = load; h_err = error;
        if (exp_q.size() == 0) begin
          chk("unexpected_ready", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("load", load, e.load);
          chk("error", {31'b0, error}, {31'b0, e.err});
        end
      end else begin
        chk("load_stable", load, h_load);
        chk("error_stable", {31'b0, error}, {31'b0, h_err});
      end
    end
  end

  // Bus monitor: every handshake must match the next expected beat.
  initial begin : bus_mon
    aw_t ea; w_t ew; logic [31:0] er;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (awvalid && awready) begin
          if (aw_q.size() == 0) chk("unexpected_aw", awaddr, 32'hFFFF_FFFF);
          else begin
            ea = aw_q.pop_front();
            chk("awaddr", awaddr, ea.a);
            chk("awsize", {29'b0, awsize}, {29'b0, ea.size});
          end
        end
        if (wvalid && wready) begin
          if (w_q.size() == 0) chk("unexpected_w", wdata, 32'hFFFF_FFFF);
          else begin
            ew = w_q.pop_front();
            chk("wdata", wdata, ew.d);
            chk("wstrb", {28'b0, wstrb}, {28'b0, ew.strb});
          end
        end
        if (arvalid && arready) begin
          if (ar_q.size() == 0) chk("unexpected_ar", araddr, 32'hFFFF_FFFF);
          else begin
            er = ar_q.pop_front();
            chk("araddr", araddr, er);
            chk("arsize", {29'b0, arsize}, 32'd2);
          end
        end
      end
    end
  end

  task automatic exp_wr(input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] d, input logic [3:0] s);
    aw_q.push_back('{a: a, size: sz});
    w_q.push_back('{d: d, strb: s});
  endtask

  // One CPU transaction; elat=0 skips the latency check.
  task automatic run(input logic rd, input logic [1:0] wr, input logic [31:0] a,
                     input logic [31:0] st, input logic [31:0] eload,
                     input logic eerr, input int elat);
    int lat;
    exp_q.push_back('{load: eload, err: eerr});
    @(negedge clk);
    read = rd; write = wr; addr = a; store = st;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!ready && lat < 400);
    chk("ready_seen", {31'b0, ready}, 32'd1);
    if (elat != 0) chk("latency", lat, elat);
    repeat (2) @(posedge clk);
    @(negedge clk); done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0; read = 1'b0; write = 2'b00;
    chk("ready_drop", {31'b0, ready}, 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    int guard;
    rst = 1'b1; read = 1'b0; write = 2'b00; addr = '0; store = '0; done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_error", {31'b0, error}, 32'd0);
    chk("rst_load", load, 32'd0);
    chk("rst_valids", {28'b0, awvalid, wvalid, arvalid, bready | rready}, 32'd0);
    rst = 1'b0;

    // Word write, zero-wait slave
    exp_wr(32'h2004_0104, 3'b010, 32'h0000_0019, 4'b1111);
    run(1'b0, 2'b11, 32'h2004_0104, 32'd25, 32'h0, 1'b0, 3);
    // Byte write to lane 2
    exp_wr(32'h2004_0102, 3'b000, 32'hABAB_ABAB, 4'b0100);
    run(1'b0, 2'b01, 32'h2004_0102, 32'h0000_00AB, 32'h0, 1'b0, 3);
    // Read with 5 wait cycles on R
    r_wait = 5; rdata_cfg = 32'h1234_5678;
    ar_q.push_back(32'h2004_0100);
    run(1'b1, 2'b00, 32'h2004_0100, 32'h0, 32'h1234_5678, 1'b0, 8);
    r_wait = 0;
    // Misaligned half write: no bus activity, load forced to 0
    run(1'b0, 2'b10, 32'h2004_0101, 32'h0000_1234, 32'h0, 1'b1, 1);
    // Legal half write answered with SLVERR
    bresp_cfg = 2'b10;
    exp_wr(32'h2004_0102, 3'b001, 32'hBEEF_BEEF, 4'b1100);
    run(1'b0, 2'b10, 32'h2004_0102, 32'h0000_BEEF, 32'h0, 1'b1, 3);
    bresp_cfg = 2'b00;
    // Zero-wait read
    rdata_cfg = 32'hCAFE_F00D;
    ar_q.push_back(32'h2004_0108);
    run(1'b1, 2'b00, 32'h2004_0108, 32'h0, 32'hCAFE_F00D, 1'b0, 3);
    // Read and write together: write wins, load retained
    exp_wr(32'h2004_0110, 3'b010, 32'h55AA_1234, 4'b1111);
    run(1'b1, 2'b11, 32'h2004_0110, 32'h55AA_1234, 32'hCAFE_F00D, 1'b0, 3);
    // Misaligned read
    run(1'b1, 2'b00, 32'h2004_0103, 32'h0, 32'h0, 1'b1, 1);
    // Read answered with DECERR
    rresp_cfg = 2'b11; rdata_cfg = 32'h0BAD_F00D;
    ar_q.push_back(32'h2004_010C);
    run(1'b1, 2'b00, 32'h2004_010C, 32'h0, 32'h0BAD_F00D, 1'b1, 3);
    rresp_cfg = 2'b00;

    // Reset while waiting in RDATA
    r_wait = 100;
    ar_q.push_back(32'h2004_0100);
    @(negedge clk);
    read = 1'b1; addr = 32'h2004_0100;
    guard = 0;
    while (!rready && guard < 20) begin @(negedge clk); guard++; end
    chk("rready_reached", {31'b0, rready}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_rready", {31'b0, rready}, 32'd0);
    chk("rst_mid_valids", {29'b0, arvalid, awvalid, ready}, 32'd0);
    chk("rst_mid_load", load, 32'd0);
    @(negedge clk);
    rst = 1'b0; read = 1'b0; r_wait = 0;

    // Byte write to top lane after reset
    exp_wr(32'h2004_0003, 3'b000, 32'h7F7F_7F7F, 4'b1000);
    run(1'b0, 2'b01, 32'h2004_0003, 32'h0000_007F, 32'h0, 1'b0, 3);

`ifdef AXI_CTRL_TIMEOUT_EN
    // AW never accepted: W still handshakes, then the timeout fires
    aw_en = 1'b0;
    w_q.push_back('{d: 32'h1111_1111, strb: 4'b1111});
    run(1'b0, 2'b11, 32'h2004_0200, 32'h1111_1111, 32'hDEAD_BEEF, 1'b1, 257);
    aw_en = 1'b1;
`endif

    repeat (3) @(posedge clk);
    chk("pending_resp", exp_q.size(), 32'd0);
    chk("pending_aw", aw_q.size(), 32'd0);
    chk("pending_w", w_q.size(), 32'd0);
    chk("pending_ar", ar_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
